ldpc_shift_arbiter: RTL
=======================

// Module: ldpc_shift_arbiter
// PURPOSE
//  Shares one pipelinedCircularShifter between NREQ requesters, e.g. the check-node units of the QC-LDPC decoder.
//  The shifter takes one operand at a time and has a shift-dependent latency.
//  This block arbitrates round-robin, issues one rotate at a time, waits for valid_out and returns the result.
//  It tags each result with the requester id and guards each operation with a watchdog timeout.
// PARAMETERS
//  MAXZ     81               lifting size; width of data words
//  NREQ     4                number of requesters (2..16)
//  SW       $clog2(MAXZ)     width of shift values
//  TIMEOUT  127              max cycles in WAIT before aborting (>= worst-case shifter latency + 2)
//  IDW      $clog2(NREQ)     requester id width (derived)
// PORTS
//  CLK            in   1          clock, rising edge
//  rst            in   1          asynchronous reset, active-high
//  req_valid      in   NREQ       per-requester request valid
//  req_ready      out  NREQ       one-hot accept strobe; a request transfers on valid&ready
//  req_data       in   NREQ*MAXZ  packed operands; requester i occupies [i*MAXZ +: MAXZ]
//  req_shift      in   NREQ*SW    packed rotate-right amounts; requester i occupies [i*SW +: SW]
//  rsp_valid      out  1          response valid; held until rsp_ready
//  rsp_ready      in   1          response consumer ready
//  rsp_id         out  IDW        id of the requester that owns the response
//  rsp_data       out  MAXZ       rotated word (0 when rsp_err=1)
//  rsp_err        out  1          1 = shift out of range or timeout
//  sh_valid_in    out  1          to shifter valid_in
//  sh_in_data     out  MAXZ       to shifter in_data
//  sh_shift_val   out  SW         to shifter shift_val
//  sh_valid_out   in   1          from shifter valid_out
//  sh_out_data    in   MAXZ       from shifter out_data
//  busy           out  1          high in every state except IDLE
//  timeout_cnt    out  8          saturating count of timed-out operations
// BEHAVIOUR
//  Reset:
//   - All outputs 0; state=IDLE; RR pointer=0; watchdog=0; timeout_cnt=0.
//   - The shifter shares rst, so an operation in flight is discarded on both sides.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Only one operation is in flight.
//  IDLE:
//   - If any req_valid is set, grant the first valid requester at or after the pointer, searching upward with wrap.
//   - In that cycle, req_ready[g]=1 (combinational from registered state and req_valid).
//   - Latch data, shift and id=g.
//   - If the latched shift >= MAXZ, go to RESP with err=1 and data=0. The shifter is not used.
//   - Otherwise go to ISSUE.
//  ISSUE: sh_valid_in=1 for exactly 1 cycle with the latched data and shift; clear the watchdog; go to WAIT.
//  WAIT:
//   - The watchdog increments each cycle.
//   - On sh_valid_out=1: capture sh_out_data, set err=0, go to RESP.
//   - Else if the watchdog reaches TIMEOUT: set data=0 and err=1, increment timeout_cnt (saturating at 255), go to RESP.
//   - If sh_valid_out arrives in the same cycle the watchdog reaches TIMEOUT, the valid result wins.
//  RESP:
//   - rsp_valid=1; rsp_id, rsp_data and rsp_err are stable until rsp_ready=1.
//   - On the handshake: pointer = (id+1) mod NREQ, go to IDLE.
//  Ignored inputs:
//   - sh_valid_out in IDLE, ISSUE or RESP is ignored; a stale late result is never forwarded.
//   - req_valid changes outside IDLE have no effect; requesters hold requests until req_ready.
//  Throughput: 1 op per (shifter latency + 3 cycles + rsp stall).
//  Fairness: a continuously-valid requester waits at most NREQ-1 grants.
//  Latency: request accept to rsp_valid = 2 + shifter latency cycles; an error on accept gives 1 cycle.
// TESTING
//  - Reset mid-WAIT (assert rst 3 cycles after ISSUE) -> next cycle busy=0, rsp_valid=0, state IDLE, pointer 0.
//  - Single request id 2, data=81'h1, shift=1 with a real shifter (ROTATES_PER_CYCLE=1, 4, 7):
//    -> rsp_id=2, rsp_data=1<<80, rsp_err=0.
//  - All 4 requesters valid continuously, 8 ops -> grant order 0,1,2,3,0,1,2,3; each gets exactly 2 responses.
//  - req_shift=81 from requester 1 -> rsp_err=1, rsp_data=0, sh_valid_in never asserted, pointer advances to 2.
//  - Stub shifter never asserts valid_out, TIMEOUT=127 -> rsp_err=1 exactly 127 cycles after WAIT entry, timeout_cnt=1.
//    A stray sh_valid_out injected afterwards in IDLE produces no response.
//  - rsp_ready held low for 10 cycles in RESP -> rsp_* stable, req_ready stays 0.
//    Then 500 random ops (shift 0..80) all match the rotate-right reference model.

Source files
------------

// File: rtl/ldpc_shift_arbiter.sv
// Round-robin arbiter that time-shares one circular shifter between NREQ requesters,
// tagging each result with its requester id and guarding the shifter with a watchdog.
module ldpc_shift_arbiter #(
    parameter int MAXZ    = 81,
    parameter int NREQ    = 4,
    parameter int SW      = $clog2(MAXZ),
    parameter int TIMEOUT = 127,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*MAXZ-1:0] req_data,
    input  logic [NREQ*SW-1:0]   req_shift,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [MAXZ-1:0]      rsp_data,
    output logic                 rsp_err,
    output logic                 sh_valid_in,
    output logic [MAXZ-1:0]      sh_in_data,
    output logic [SW-1:0]        sh_shift_val,
    input  logic                 sh_valid_out,
    input  logic [MAXZ-1:0]      sh_out_data,
    output logic                 busy,
    output logic [7:0]           timeout_cnt,
    output logic [1:0]           dbg_state,
    output logic [IDW-1:0]       dbg_ptr
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [MAXZ-1:0] data_q, data_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic            err_q, err_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [7:0]      tcnt_q, tcnt_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_id;

    // Handshakes: a request moves on req_valid[i] & req_ready[i]; a response
    // moves on rsp_valid & rsp_ready, and rsp_* hold steady until that happens.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && gnt_found) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        data_d  = data_q;
        shift_d = shift_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    id_d    = gnt_id;
                    data_d  = req_data[int'(gnt_id)*MAXZ +: MAXZ];
                    shift_d = req_shift[int'(gnt_id)*SW +: SW];
                    // Out-of-range rotates are answered directly without touching the shifter.
                    if ({1'b0, shift_d} >= (SW+1)'(MAXZ)) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (sh_valid_out) begin
                    data_d  = sh_out_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
            shift_q <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_id       = id_q;
    assign rsp_data     = data_q;
    assign rsp_err      = err_q;
    assign sh_valid_in  = (state_q == S_ISSUE);
    assign sh_in_data   = data_q;
    assign sh_shift_val = shift_q;
    assign busy         = (state_q != S_IDLE);
    assign timeout_cnt  = tcnt_q;
    assign dbg_state    = state_q;
    assign dbg_ptr      = ptr_q;

endmodule
